// File: rtl/l1_trigger_scheduler_pkg.sv
// Shared types and field layout for the L1 trigger scheduler.
package l1_trig_sched_pkg;

   // Event word layout: {timestamp, beam index}, beam index in the low byte.
   localparam int BEAM_IDX_BITS = 8;
   localparam int BEAM_LSB      = 0;
   localparam int TS_LSB        = BEAM_IDX_BITS;
   localparam int EVT_TS_BITS   = 32;

   typedef struct packed {
      logic [EVT_TS_BITS-1:0]   ts;
      logic [BEAM_IDX_BITS-1:0] beam;
   } evt_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Packs a timestamp and beam index into the event layout.
   function automatic evt_t make_evt(input logic [EVT_TS_BITS-1:0] ts,
                                     input logic [BEAM_IDX_BITS-1:0] beam);
      evt_t e;
      e.ts   = ts;
      e.beam = beam;
      return e;
   endfunction

endpackage

// File: rtl/l1_trigger_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational grant, registered last grant.
// Search begins one past the last grant and wraps; beam 0 wins first after reset.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          aclk,
   input  logic          reset_i,
   input  logic [N-1:0]  req_i,
   input  logic          advance_i,
   output logic [IW-1:0] grant_o,
   output logic          grant_vld_o
);

   localparam int SW = IW + 1;

   logic [IW-1:0] last_grant_q;
   logic [SW-1:0] cand;

   // Pick the first requester after the last grant, wrapping at N.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      grant_o     = '0;
      grant_vld_o = 1'b0;
      cand        = '0;
      for (int i = 1; i <= N; i++) begin
         cand = {1'b0, last_grant_q} + SW'(i);
         if (cand >= SW'(N)) cand = cand - SW'(N);
         if (!grant_vld_o && req_i[cand[IW-1:0]]) begin
            grant_vld_o = 1'b1;
            grant_o     = cand[IW-1:0];
         end
      end
   end

   // Remember the winner only when the grant is actually taken.
   always_ff @(posedge aclk or posedge reset_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset_i) last_grant_q <= IW'(N - 1);
      else if (advance_i) last_grant_q <= grant_o;
   end

endmodule

// File: rtl/l1_trigger_scheduler.sv
// L1 trigger scheduler: edge detect, mask, holdoff, timestamp and
// round-robin drain of per-beam triggers onto one AXI4-Stream event port.
// Optional drop statistics: define L1_TRIG_SCHED_STATS_EN to add drop_count_o.
module l1_trigger_scheduler
   import l1_trig_sched_pkg::*;
#(
   parameter int NBEAMS       = 2,
   parameter int HOLDOFF_BITS = 8,
   parameter int TS_BITS      = 32
) (
   input  logic                             aclk,
   input  logic                             reset_i,
   input  logic [NBEAMS-1:0]                trig_i,
   input  logic                             enable_i,
   input  logic [NBEAMS-1:0]                mask_i,
   input  logic [HOLDOFF_BITS-1:0]          holdoff_i,
`ifdef L1_TRIG_SCHED_STATS_EN
   output logic [15:0]                      drop_count_o,
`endif
   output logic [TS_BITS+BEAM_IDX_BITS-1:0] evt_tdata,
   output logic                             evt_tvalid,
   input  logic                             evt_tready
);

   localparam int IW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;

   logic [TS_BITS-1:0]      ts_q;
   logic [NBEAMS-1:0]       trig_q;
   logic [NBEAMS-1:0]       pending_q, pending_d;
   logic [TS_BITS-1:0]      ts_lat_q [NBEAMS];
   logic [HOLDOFF_BITS-1:0] hold_q   [NBEAMS];
   logic [NBEAMS-1:0]       rise_ok, busy, accept, grant_clr;
   logic [IW-1:0]           grant;
   logic                    grant_vld, do_grant;
   state_t                  state_q;
   logic                    evt_tvalid_q;
   logic [TS_BITS+BEAM_IDX_BITS-1:0] evt_tdata_q;

   // Qualified rising edges, and beams that cannot take a new trigger yet.
   always_comb begin
      rise_ok = trig_i & ~trig_q & ~mask_i & {NBEAMS{enable_i}};
      busy    = '0;
      for (int b = 0; b < NBEAMS; b++) begin
         busy[b] = pending_q[b] | (hold_q[b] != '0);
      end
   end

   assign accept   = rise_ok & ~busy;
   assign do_grant = (state_q == EMPTY) && grant_vld;

   // Pending update: granted beam cleared, a new acceptance sets (set wins).
   always_comb begin
      grant_clr = '0;
      if (do_grant) grant_clr[grant] = 1'b1;
      pending_d = (pending_q & ~grant_clr) | accept;
   end

   // Free-running timestamp, edge-detect history and pending flags.
   always_ff @(posedge aclk or posedge reset_i) begin
      if (reset_i) begin
         ts_q      <= '0;
         trig_q    <= '0;
         pending_q <= '0;
      end else begin
         ts_q      <= ts_q + 1'b1;
         trig_q    <= trig_i;
         pending_q <= pending_d;
      end
   end

   // Per-beam latched timestamp and holdoff countdown.
   always_ff @(posedge aclk or posedge reset_i) begin
      // NOTE: these small arrays are reset explicitly; a stale holdoff or timestamp must not survive reset.
      if (reset_i) begin
         for (int b = 0; b < NBEAMS; b++) begin
            ts_lat_q[b] <= '0;
            hold_q[b]   <= '0;
         end
      end else begin
         for (int b = 0; b < NBEAMS; b++) begin
            if (accept[b]) begin
               ts_lat_q[b] <= ts_q;
               hold_q[b]   <= holdoff_i;
            end else if (hold_q[b] != '0) begin
               hold_q[b] <= hold_q[b] - 1'b1;
            end
         end
      end
   end

   rr_arbiter #(.N(NBEAMS)) u_arb (
      .aclk        (aclk),
      .reset_i     (reset_i),
      .req_i       (pending_q),
      .advance_i   (do_grant),
      .grant_o     (grant),
      .grant_vld_o (grant_vld)
   );

   // Output FSM: load one event when empty, hold it until the handshake.
   always_ff @(posedge aclk or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= EMPTY;
         evt_tvalid_q <= 1'b0;
         evt_tdata_q  <= '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (grant_vld) begin
                  evt_tdata_q[TS_LSB +: TS_BITS]         <= ts_lat_q[grant];
                  evt_tdata_q[BEAM_LSB +: BEAM_IDX_BITS] <= BEAM_IDX_BITS'(grant);
                  evt_tvalid_q <= 1'b1;
                  state_q      <= FULL;
               end
            end
            FULL: begin
               if (evt_tready) begin
                  evt_tvalid_q <= 1'b0;
                  state_q      <= EMPTY;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   assign evt_tvalid = evt_tvalid_q;
   assign evt_tdata  = evt_tdata_q;

`ifdef L1_TRIG_SCHED_STATS_EN
   logic [NBEAMS-1:0] drop;
   logic [15:0]       drop_cnt_q;
   logic [16:0]       drop_sum;

   assign drop     = rise_ok & busy;
   assign drop_sum = {1'b0, drop_cnt_q} + 17'($countones(drop));

   // Saturating count of edges lost to pending or holdoff.
   always_ff @(posedge aclk or posedge reset_i) begin
      if (reset_i) drop_cnt_q <= '0;
      else drop_cnt_q <= (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
   end

   assign drop_count_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_l1_trigger_scheduler.sv
// Directed bench for l1_trigger_scheduler with a cycle-level behavioural
// model (holdoff as timestamp arithmetic, round-robin as a wrap search).
module tb_l1_trigger_scheduler;
   import l1_trig_sched_pkg::*;

   localparam int NB = 2;
   localparam int HB = 8;
   localparam int TB = 32;
   localparam int DW = TB + BEAM_IDX_BITS;

   logic          aclk       = 1'b0;
   logic          reset_i    = 1'b1;
   logic [NB-1:0] trig_i     = '0;
   logic          enable_i   = 1'b1;
   logic [NB-1:0] mask_i     = '0;
   logic [HB-1:0] holdoff_i  = 8'd4;
   logic          evt_tready = 1'b1;
   logic [DW-1:0] evt_tdata;
   logic          evt_tvalid;
`ifdef L1_TRIG_SCHED_STATS_EN
   logic [15:0]   drop_count_o;
`endif

   int checks  = 0;
   int errors  = 0;
   logic run_chk = 1'b0;

   always #5 aclk = ~aclk;

   l1_trigger_scheduler #(.NBEAMS(NB), .HOLDOFF_BITS(HB), .TS_BITS(TB)) dut (
      .aclk         (aclk),
      .reset_i      (reset_i),
      .trig_i       (trig_i),
      .enable_i     (enable_i),
      .mask_i       (mask_i),
      .holdoff_i    (holdoff_i),
`ifdef L1_TRIG_SCHED_STATS_EN
      .drop_count_o (drop_count_o),
`endif
      .evt_tdata    (evt_tdata),
      .evt_tvalid   (evt_tvalid),
      .evt_tready   (evt_tready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int            m_ts;
   int            m_ready_at [NB];
   logic [TB-1:0] m_pts      [NB];
   logic [NB-1:0] m_trig_d, m_pend, m_acc;
   logic          m_valid, m_found;
   logic [DW-1:0] m_data;
   int            m_last, m_b, m_drops;

   always @(posedge aclk or posedge reset_i) begin
      if (reset_i) begin
         m_ts = 0; m_trig_d = '0; m_pend = '0; m_valid = 1'b0; m_data = '0;
         m_last = NB - 1; m_drops = 0;
         for (int b = 0; b < NB; b++) begin
            m_ready_at[b] = 0;
            m_pts[b]      = '0;
         end
      end else begin
         m_acc = '0;
         for (int b = 0; b < NB; b++) begin
            if (trig_i[b] && !m_trig_d[b] && enable_i && !mask_i[b]) begin
               if (m_pend[b] || m_ts < m_ready_at[b]) m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
               else m_acc[b] = 1'b1;
            end
         end
         if (m_valid) begin
            if (evt_tready) m_valid = 1'b0;
         end else begin
            m_found = 1'b0;
            for (int k = 1; k <= NB; k++) begin
               m_b = (m_last + k) % NB;
               if (!m_found && m_pend[m_b]) begin
                  m_found     = 1'b1;
                  m_last      = m_b;
                  m_pend[m_b] = 1'b0;
                  m_data      = make_evt(m_pts[m_b], 8'(m_b));
                  m_valid     = 1'b1;
               end
            end
         end
         for (int b = 0; b < NB; b++) begin
            if (m_acc[b]) begin
               m_pend[b]     = 1'b1;
               m_pts[b]      = TB'(m_ts);
               m_ready_at[b] = m_ts + int'(holdoff_i) + 1;
            end
         end
         m_ts++;
         m_trig_d = trig_i;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge aclk) begin
      if (run_chk && !reset_i) begin
         check("cmp_tvalid", 64'(evt_tvalid), 64'(m_valid));
         if (m_valid) check("cmp_tdata", 64'(evt_tdata), 64'(m_data));
`ifdef L1_TRIG_SCHED_STATS_EN
         check("cmp_drops", 64'(drop_count_o), 64'(m_drops));
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic pulse(input logic [NB-1:0] v);
      trig_i = v;
      tick(1);
      trig_i = '0;
   endtask

   task automatic wait_ts(input int t);
      int guard;
      guard = 0;
      while (m_ts != t && guard < 2000) begin
         tick(1);
         guard++;
      end
      if (guard >= 2000) begin
         checks++;
         errors++;
         $display("FAIL wait_ts actual=%0d expected=%0d", m_ts, t);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, m, p, t0, b0, b1t;

      // Reset values
      tick(3);
      check("rst_tvalid", 64'(evt_tvalid), 64'd0);
      check("rst_tdata",  64'(evt_tdata),  64'd0);
`ifdef L1_TRIG_SCHED_STATS_EN
      check("rst_drops",  64'(drop_count_o), 64'd0);
`endif
      reset_i = 1'b0;
      run_chk = 1'b1;

      // Single edge on beam 1 at ts=100: event two cycles later
      wait_ts(100);
      pulse(2'b10);
      check("t1_lat1",  64'(evt_tvalid), 64'd0);
      tick(1);
      check("t1_valid", 64'(evt_tvalid), 64'd1);
      check("t1_data",  64'(evt_tdata),  64'(make_evt(32'd100, 8'd1)));
      tick(1);
      check("t1_done",  64'(evt_tvalid), 64'd0);

      // Both beams together: beam 0 first (last grant was beam 1)
      tick(5);
      n = m_ts;
      pulse(2'b11);
      tick(1);
      check("t2_first",  64'(evt_tdata), 64'(make_evt(TB'(n), 8'd0)));
      tick(1);
      check("t2_gap",    64'(evt_tvalid), 64'd0);
      tick(1);
      check("t2_second", 64'(evt_tdata), 64'(make_evt(TB'(n), 8'd1)));

      // Beam 0 alone, then both: beam 1 now has priority
      tick(6);
      m = m_ts;
      pulse(2'b01);
      tick(1);
      check("t2_solo",   64'(evt_tdata), 64'(make_evt(TB'(m), 8'd0)));
      tick(6);
      p = m_ts;
      pulse(2'b11);
      tick(1);
      check("t2_rr_b1",  64'(evt_tdata), 64'(make_evt(TB'(p), 8'd1)));
      tick(2);
      check("t2_rr_b0",  64'(evt_tdata), 64'(make_evt(TB'(p), 8'd0)));

      // Holdoff 4: edges at t0, t0+3 (dropped), t0+5 (accepted)
      tick(8);
      t0 = m_ts;
      pulse(2'b01);
      tick(2);
      pulse(2'b01);
      tick(1);
      pulse(2'b01);
      tick(1);
      check("t3_valid", 64'(evt_tvalid), 64'd1);
      check("t3_data",  64'(evt_tdata),  64'(make_evt(TB'(t0 + 5), 8'd0)));
`ifdef L1_TRIG_SCHED_STATS_EN
      check("t3_drops", 64'(drop_count_o), 64'd1);
`endif

      // Backpressure: event held, second beam waits for the handshake
      tick(4);
      evt_tready = 1'b0;
      b0 = m_ts;
      pulse(2'b01);
      tick(3);
      b1t = m_ts;
      pulse(2'b10);
      tick(18);
      check("t4_held_v", 64'(evt_tvalid), 64'd1);
      check("t4_held_d", 64'(evt_tdata),  64'(make_evt(TB'(b0), 8'd0)));
      evt_tready = 1'b1;
      tick(1);
      check("t4_gap",    64'(evt_tvalid), 64'd0);
      tick(1);
      check("t4_next",   64'(evt_tdata),  64'(make_evt(TB'(b1t), 8'd1)));
      tick(2);

      // Masked and disabled edges: no events, no drops
      mask_i = 2'b01;
      pulse(2'b01);
      tick(4);
      check("t5_mask",  64'(evt_tvalid), 64'd0);
      mask_i   = 2'b00;
      enable_i = 1'b0;
      pulse(2'b01);
      tick(4);
      check("t5_dis",   64'(evt_tvalid), 64'd0);
`ifdef L1_TRIG_SCHED_STATS_EN
      check("t5_drops", 64'(drop_count_o), 64'd1);
`endif
      enable_i = 1'b1;
      tick(2);

      // Reset with an event in flight and another pending
      evt_tready = 1'b0;
      pulse(2'b11);
      tick(2);
      pulse(2'b01);
      check("t6_pre_v", 64'(evt_tvalid), 64'd1);
`ifdef L1_TRIG_SCHED_STATS_EN
      check("t6_pre_drops", 64'(drop_count_o), 64'd2);
`endif
      #2;
      reset_i = 1'b1;
      #1;
      check("t6_rst_v", 64'(evt_tvalid), 64'd0);
      check("t6_rst_d", 64'(evt_tdata),  64'd0);
`ifdef L1_TRIG_SCHED_STATS_EN
      check("t6_rst_drops", 64'(drop_count_o), 64'd0);
`endif
      tick(2);
      evt_tready = 1'b1;
      reset_i    = 1'b0;
      tick(10);
      check("t6_no_stale", 64'(evt_tvalid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
